// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the 5-stage RV32I pipeline.
// Define HAZ_WATCHDOG_EN to add the data-memory wait watchdog (mem_timeout).
module pipe_hazard_ctrl #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int LOAD_USE_BUBBLES    = 1,
    parameter int COUNT_WIDTH         = 16,
    parameter int MEM_TIMEOUT         = 255
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    input  logic                           reg_write_EX,
    input  logic [1:0]                     result_sel_EX,
    input  logic                           redirect_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM,
    input  logic                           reg_write_MEM,
    input  logic [1:0]                     result_sel_MEM,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_WB,
    input  logic                           reg_write_WB,
    input  logic                           inst_mem_hazard,
    input  logic                           data_mem_hazard,
    output logic                           stall_PC_IF,
    output logic                           stall_IF_ID,
    output logic                           stall_ID_EX,
    output logic                           stall_EX_MEM,
    output logic                           stall_MEM_WB,
    output logic                           flush_IF_ID,
    output logic                           flush_ID_EX,
    output logic [2:0]                     forward_detect_EX_rs1,
    output logic [2:0]                     forward_detect_EX_rs2,
    output logic [COUNT_WIDTH-1:0]         stall_cycle_count,
    output logic                           mem_timeout
);
    typedef enum logic [1:0] {RUN = 2'd0, LU_HOLD = 2'd1, MEM_FREEZE = 2'd2} state_t;

    localparam logic [2:0] BUB_RELOAD = 3'(LOAD_USE_BUBBLES - 1);

    state_t                 state_q, state_d, eff_state;
    logic [2:0]             bub_q, bub_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   timeout_q, wd_fire, dmh, lu;

    if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 4 || MEM_TIMEOUT < 1) begin : g_param_chk
        $error("pipe_hazard_ctrl: LOAD_USE_BUBBLES must be 1..4 and MEM_TIMEOUT >= 1");
    end

    // EX_MEM beats WB; loads in EX_MEM have no data yet, and x0 is never forwarded.
    function automatic logic [2:0] fwd_sel(input logic [REGISTER_ADDR_WIDTH-1:0] rs);
        logic [2:0] sel;
        sel = 3'b000;
        if (reg_write_MEM && rd_MEM != '0 && rd_MEM == rs && result_sel_MEM != 2'b01)
            sel = 3'b001;
        else if (reg_write_WB && rd_WB != '0 && rd_WB == rs)
            sel = 3'b010;
        return sel;
    endfunction

    assign forward_detect_EX_rs1 = fwd_sel(rs1_EX);
    assign forward_detect_EX_rs2 = fwd_sel(rs2_EX);

    assign dmh = data_mem_hazard && !timeout_q;
    assign lu  = reg_write_EX && result_sel_EX == 2'b01 && rd_EX != '0 &&
                 (rd_EX == rs1_ID || rd_EX == rs2_ID);

`ifdef HAZ_WATCHDOG_EN
    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_d;

    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        wd_fire   = 1'b0;
        if (state_q == MEM_FREEZE && dmh) begin
            wait_d = wait_q + 1'b1;
            if (wait_d == WAIT_W'(MEM_TIMEOUT)) begin
                wd_fire   = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout_q = 1'b0;
    assign wd_fire   = 1'b0;
`endif

    assign mem_timeout = timeout_q;

    always_comb begin
        // A freeze that ends this cycle behaves exactly like the state it resumes.
        eff_state = state_q;
        if (state_q == MEM_FREEZE && !dmh)
            eff_state = (bub_q != '0) ? LU_HOLD : RUN;

        state_d      = eff_state;
        bub_d        = bub_q;
        stall_PC_IF  = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        stall_MEM_WB = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;

        if (dmh) begin
            {stall_PC_IF, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = 5'b11111;
            state_d = wd_fire ? RUN : MEM_FREEZE;
            if (wd_fire)
                bub_d = '0;
        end else begin
            case (eff_state)
                LU_HOLD: begin
                    stall_PC_IF = 1'b1;
                    stall_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                    bub_d       = bub_q - 1'b1;
                    state_d     = (bub_q == 3'd1) ? RUN : LU_HOLD;
                end
                default: begin
                    state_d = RUN;
                    if (redirect_EX) begin
                        flush_IF_ID = 1'b1;
                        flush_ID_EX = 1'b1;
                    end else if (lu || inst_mem_hazard) begin
                        stall_PC_IF = 1'b1;
                        stall_IF_ID = 1'b1;
                        flush_ID_EX = 1'b1;
                        if (lu && LOAD_USE_BUBBLES > 1) begin
                            bub_d   = BUB_RELOAD;
                            state_d = LU_HOLD;
                        end
                    end
                end
            endcase
        end

        if (!cpu_rst_n) begin
            {stall_PC_IF, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = 5'b00000;
            flush_IF_ID = 1'b0;
            flush_ID_EX = 1'b0;
        end
    end

    assign cnt_d = (stall_PC_IF && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= RUN;
            bub_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycle_count = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1 and 3 load-use bubbles) run against an
// owed-bubble/freeze model under directed and random stimulus.
module tb_pipe_hazard_ctrl;
    localparam int TB_TIMEOUT = 10;
    localparam logic [6:0] C_BUB    = 7'b1100001;
    localparam logic [6:0] C_FREEZE = 7'b1111100;
    localparam logic [6:0] C_REDIR  = 7'b0000011;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst_n = 1'b0;
    logic [4:0] rs1_ID = '0, rs2_ID = '0, rs1_EX = '0, rs2_EX = '0, rd_EX = '0;
    logic [4:0] rd_MEM = '0, rd_WB = '0;
    logic       reg_write_EX = 1'b0, reg_write_MEM = 1'b0, reg_write_WB = 1'b0;
    logic [1:0] result_sel_EX = '0, result_sel_MEM = '0;
    logic       redirect_EX = 1'b0, inst_mem_hazard = 1'b0, data_mem_hazard = 1'b0;

    logic [6:0]  ctl1, ctl3;
    logic [2:0]  f1_rs1, f1_rs2, f3_rs1, f3_rs2;
    logic [15:0] cnt1;
    logic [3:0]  cnt3;
    logic        tmo1, tmo3;

    int n_cmp = 0;
    int n_err = 0;

    // model state: bubbles still owed, freeze flag, freeze length, sticky timeout, stall count
    int m_pend[2], m_wait[2], m_cnt[2];
    bit m_frozen[2], m_to[2];
    int n_pend[2], n_wait[2], n_cnt[2];
    bit n_frozen[2], n_to[2];
    int mb[2]   = '{1, 3};
    int cmax[2] = '{65535, 15};
    logic [6:0] obs[2];

    always #5 cpu_clk = ~cpu_clk;

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .COUNT_WIDTH(16), .MEM_TIMEOUT(TB_TIMEOUT)) u_dut1 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .rd_EX(rd_EX), .reg_write_EX(reg_write_EX), .result_sel_EX(result_sel_EX),
        .redirect_EX(redirect_EX), .rd_MEM(rd_MEM), .reg_write_MEM(reg_write_MEM),
        .result_sel_MEM(result_sel_MEM), .rd_WB(rd_WB), .reg_write_WB(reg_write_WB),
        .inst_mem_hazard(inst_mem_hazard), .data_mem_hazard(data_mem_hazard),
        .stall_PC_IF(ctl1[6]), .stall_IF_ID(ctl1[5]), .stall_ID_EX(ctl1[4]),
        .stall_EX_MEM(ctl1[3]), .stall_MEM_WB(ctl1[2]),
        .flush_IF_ID(ctl1[1]), .flush_ID_EX(ctl1[0]),
        .forward_detect_EX_rs1(f1_rs1), .forward_detect_EX_rs2(f1_rs2),
        .stall_cycle_count(cnt1), .mem_timeout(tmo1)
    );

    pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .COUNT_WIDTH(4), .MEM_TIMEOUT(TB_TIMEOUT)) u_dut3 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .rd_EX(rd_EX), .reg_write_EX(reg_write_EX), .result_sel_EX(result_sel_EX),
        .redirect_EX(redirect_EX), .rd_MEM(rd_MEM), .reg_write_MEM(reg_write_MEM),
        .result_sel_MEM(result_sel_MEM), .rd_WB(rd_WB), .reg_write_WB(reg_write_WB),
        .inst_mem_hazard(inst_mem_hazard), .data_mem_hazard(data_mem_hazard),
        .stall_PC_IF(ctl3[6]), .stall_IF_ID(ctl3[5]), .stall_ID_EX(ctl3[4]),
        .stall_EX_MEM(ctl3[3]), .stall_MEM_WB(ctl3[2]),
        .flush_IF_ID(ctl3[1]), .flush_ID_EX(ctl3[0]),
        .forward_detect_EX_rs1(f3_rs1), .forward_detect_EX_rs2(f3_rs2),
        .stall_cycle_count(cnt3), .mem_timeout(tmo3)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned fwd_exp(input logic [4:0] rs);
        if (reg_write_MEM && rd_MEM != 0 && rd_MEM == rs && result_sel_MEM != 2'b01) return 1;
        if (reg_write_WB && rd_WB != 0 && rd_WB == rs) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_wait[d] = 0; m_cnt[d] = 0; m_frozen[d] = 0; m_to[d] = 0;
        end
    endtask

    task automatic model_eval(input int d, output logic [6:0] c);
        bit dm, lu_now;
        dm     = data_mem_hazard && !m_to[d];
        lu_now = reg_write_EX && result_sel_EX == 2'b01 && rd_EX != 0 &&
                 (rd_EX == rs1_ID || rd_EX == rs2_ID);
        c = '0;
        n_pend[d] = m_pend[d]; n_frozen[d] = m_frozen[d];
        n_wait[d] = m_wait[d]; n_to[d] = m_to[d];
        if (dm) begin
            c = C_FREEZE;
            if (m_frozen[d]) begin
                n_wait[d] = m_wait[d] + 1;
`ifdef HAZ_WATCHDOG_EN
                if (n_wait[d] == TB_TIMEOUT) begin
                    n_to[d] = 1; n_frozen[d] = 0; n_pend[d] = 0;
                end
`endif
            end else begin
                n_frozen[d] = 1;
            end
        end else begin
            n_frozen[d] = 0;
            n_wait[d]   = 0;
            if (m_pend[d] > 0) begin
                c = C_BUB; n_pend[d] = m_pend[d] - 1;
            end else if (redirect_EX) begin
                c = C_REDIR;
            end else if (lu_now) begin
                c = C_BUB; n_pend[d] = mb[d] - 1;
            end else if (inst_mem_hazard) begin
                c = C_BUB;
            end
        end
        n_cnt[d] = (c[6] && m_cnt[d] < cmax[d]) ? m_cnt[d] + 1 : m_cnt[d];
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic [6:0] ec;
        #1;
        obs[0] = ctl1;
        obs[1] = ctl3;
        for (int d = 0; d < 2; d++) begin
            model_eval(d, ec);
            check_eq($sformatf("ctl_b%0d", mb[d]), 32'(obs[d]), 32'(ec));
        end
        check_eq("cnt_b1", 32'(cnt1), 32'(m_cnt[0]));
        check_eq("cnt_b3", 32'(cnt3), 32'(m_cnt[1]));
        check_eq("tmo_b1", 32'(tmo1), 32'(m_to[0]));
        check_eq("tmo_b3", 32'(tmo3), 32'(m_to[1]));
        check_eq("fwd1_rs1", 32'(f1_rs1), fwd_exp(rs1_EX));
        check_eq("fwd1_rs2", 32'(f1_rs2), fwd_exp(rs2_EX));
        check_eq("fwd3_rs1", 32'(f3_rs1), fwd_exp(rs1_EX));
        $display("t=%0t dmh=%b imh=%b rdr=%b ctl_b1=%b cnt_b1=%0d ctl_b3=%b cnt_b3=%0d fwd=%0d/%0d",
                 $time, data_mem_hazard, inst_mem_hazard, redirect_EX,
                 obs[0], cnt1, obs[1], cnt3, f1_rs1, f1_rs2);
        @(posedge cpu_clk);
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = n_pend[d]; m_frozen[d] = n_frozen[d]; m_wait[d] = n_wait[d];
            m_to[d] = n_to[d]; m_cnt[d] = n_cnt[d];
        end
        @(negedge cpu_clk);
    endtask

    task automatic quiet();
        reg_write_EX = 0; result_sel_EX = 0; rd_EX = 0; rs1_ID = 0; rs2_ID = 0;
        redirect_EX = 0; inst_mem_hazard = 0; data_mem_hazard = 0;
        reg_write_MEM = 0; reg_write_WB = 0; rd_MEM = 0; rd_WB = 0; rs1_EX = 0; rs2_EX = 0;
        result_sel_MEM = 0;
    endtask

    task automatic set_load_use();
        reg_write_EX = 1; result_sel_EX = 2'b01; rd_EX = 5'd3; rs2_ID = 5'd3; rs1_ID = 5'd7;
    endtask

    task automatic reset_now();
        #3 cpu_rst_n = 1'b0;
        #1;
        check_eq("rst_ctl_b1", 32'(ctl1), 0);
        check_eq("rst_ctl_b3", 32'(ctl3), 0);
        check_eq("rst_cnt_b1", 32'(cnt1), 0);
        check_eq("rst_cnt_b3", 32'(cnt3), 0);
        model_reset();
        @(negedge cpu_clk);
        quiet();
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
    endtask

    initial begin
        int nb1, nb3, nfz, burst;
        model_reset();
        quiet();
        data_mem_hazard = 1;
        #2;
        check_eq("rst_ctl_b1", 32'(ctl1), 0);
        check_eq("rst_cnt_b3", 32'(cnt3), 0);
        @(negedge cpu_clk);
        quiet();
        cpu_rst_n = 1'b1;

        // forwarding priority
        rd_MEM = 5; reg_write_MEM = 1; result_sel_MEM = 0; rd_WB = 5; reg_write_WB = 1; rs1_EX = 5;
        #1 check_eq("fwd_mem", 32'(f1_rs1), 1);
        reg_write_MEM = 0;
        #1 check_eq("fwd_wb", 32'(f1_rs1), 2);
        rs1_EX = 0; rd_MEM = 0; reg_write_MEM = 1;
        #1 check_eq("fwd_x0", 32'(f1_rs1), 0);
        @(negedge cpu_clk);
        step();
        quiet();

        // load-use bubble counts
        nb1 = 0; nb3 = 0;
        set_load_use();
        for (int i = 0; i < 6; i++) begin
            step();
            quiet();
            nb1 += (obs[0] == C_BUB) ? 1 : 0;
            nb3 += (obs[1] == C_BUB) ? 1 : 0;
        end
        check_eq("lu_bubbles_b1", nb1, 1);
        check_eq("lu_bubbles_b3", nb3, 3);

        // redirect beats load-use and instruction-memory wait
        set_load_use();
        inst_mem_hazard = 1; redirect_EX = 1;
        step();
        check_eq("redir_b3", 32'(obs[1]), 32'(C_REDIR));
        quiet();
        step();
        check_eq("redir_next_b3", 32'(obs[1]), 0);

        // async reset in the middle of a freeze
        data_mem_hazard = 1;
        for (int i = 0; i < 3; i++) step();
        reset_now();

        // freeze arriving during the load-use hold
        nb3 = 0; nfz = 0;
        set_load_use();
        step();
        quiet();
        data_mem_hazard = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            nfz += (obs[1] == C_FREEZE) ? 1 : 0;
        end
        data_mem_hazard = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            nb3 += (obs[1] == C_BUB) ? 1 : 0;
        end
        check_eq("frz_cycles_b3", nfz, 4);
        check_eq("frz_resume_bub_b3", nb3, 2);
        check_eq("frz_cnt_b3", 32'(cnt3), 7);

        // random traffic
        burst = 0;
        for (int n = 0; n < 1500; n++) begin
            rs1_ID = 5'($urandom_range(0, 3));   rs2_ID = 5'($urandom_range(0, 3));
            rs1_EX = 5'($urandom_range(0, 3));   rs2_EX = 5'($urandom_range(0, 3));
            rd_EX  = 5'($urandom_range(0, 3));   rd_MEM = 5'($urandom_range(0, 3));
            rd_WB  = 5'($urandom_range(0, 3));
            reg_write_EX  = 1'($urandom_range(0, 1));
            reg_write_MEM = 1'($urandom_range(0, 1));
            reg_write_WB  = 1'($urandom_range(0, 1));
            result_sel_EX  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            result_sel_MEM = 2'($urandom_range(0, 3));
            redirect_EX     = 1'($urandom_range(0, 9) < 2);
            inst_mem_hazard = 1'($urandom_range(0, 9) < 2);
            if (burst == 0 && $urandom_range(0, 99) < 8) burst = int'($urandom_range(1, 6));
            data_mem_hazard = (burst != 0);
            if (burst != 0) burst--;
            step();
        end
        quiet();

`ifdef HAZ_WATCHDOG_EN
        reset_now();
        data_mem_hazard = 1;
        for (int i = 0; i < 14; i++) step();
        check_eq("wd_timeout_b1", 32'(tmo1), 1);
        check_eq("wd_ctl_b1", 32'(obs[0]), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
